// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store sequencer: issues one data-cache request per access,
// stalls the pipeline until the response, and returns extended load data.
module lsu_mem_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        is_ls_i,
   input  logic        mem_rw_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        stall_o,
   output logic        misalign_o,
   output logic        bus_err_o,
   output logic [31:0] rdata_o,
   output logic        mem_valid_o,
   input  logic        mem_ready_i,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_wstrb_o,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i
);

   localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE
   } state_e;

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               rw_q;
   logic [2:0]         funct3_q;
   logic [1:0]         off_q;
   logic [31:0]        mem_addr_q;
   logic [31:0]        mem_wdata_q;
   logic [3:0]         mem_wstrb_q;
   logic               mem_valid_q;
   logic [31:0]        rdata_q;
   logic               bus_err_q;

   logic               misal_c;
   logic               start_c;
   logic               last_c;
   logic [3:0]         wstrb_d;
   logic [31:0]        wdata_d;
   logic [31:0]        ldata_d;
   logic [7:0]         byte_sel;
   logic [15:0]        half_sel;

   // Size decode on funct3[1:0]: 00 byte, 01 half, anything else a word.
   always_comb begin
      misal_c = 1'b0;
      wstrb_d = 4'b1111;
      wdata_d = wdata_i;
      case (funct3_i[1:0])
         2'b00: begin
            wstrb_d = 4'b0001 << addr_i[1:0];
            wdata_d = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            misal_c = addr_i[0];
            wstrb_d = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{wdata_i[15:0]}};
         end
         default: begin
            misal_c = (addr_i[1:0] != 2'b00);
         end
      endcase
      if (!mem_rw_i) begin
         wstrb_d = 4'b0000;
      end
   end

   // Lane select and extension of the returned word using the latched offset.
   always_comb begin
      byte_sel = mem_rdata_i[{off_q, 3'b000} +: 8];
      half_sel = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
      case (funct3_q)
         3'b000:  ldata_d = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  ldata_d = {{16{half_sel[15]}}, half_sel};
         3'b100:  ldata_d = {24'b0, byte_sel};
         3'b101:  ldata_d = {16'b0, half_sel};
         default: ldata_d = mem_rdata_i;
      endcase
      if (rw_q) begin
         ldata_d = 32'b0;
      end
   end

   assign start_c = (state_q == S_IDLE) && is_ls_i && !misal_c;
   assign last_c  = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rw_q        <= 1'b0;
         funct3_q    <= 3'b000;
         off_q       <= 2'b00;
         mem_addr_q  <= 32'b0;
         mem_wdata_q <= 32'b0;
         mem_wstrb_q <= 4'b0000;
         mem_valid_q <= 1'b0;
         rdata_q     <= 32'b0;
         bus_err_q   <= 1'b0;
      end else begin
         bus_err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_c) begin
                  rw_q        <= mem_rw_i;
                  funct3_q    <= funct3_i;
                  off_q       <= addr_i[1:0];
                  mem_addr_q  <= {addr_i[31:2], 2'b00};
                  mem_wdata_q <= wdata_d;
                  mem_wstrb_q <= wstrb_d;
                  mem_valid_q <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= S_REQ;
               end
            end
            S_REQ: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (last_c) begin
                  mem_valid_q <= 1'b0;
                  bus_err_q   <= 1'b1;
                  rdata_q     <= 32'b0;
                  state_q     <= S_DONE;
               end else if (mem_ready_i) begin
                  mem_valid_q <= 1'b0;
                  state_q     <= S_WAIT;
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_q + CNT_W'(1);
               // A response arriving on the final allowed cycle still wins.
               if (mem_rvalid_i) begin
                  rdata_q <= ldata_d;
                  state_q <= S_DONE;
               end else if (last_c) begin
                  bus_err_q <= 1'b1;
                  rdata_q   <= 32'b0;
                  state_q   <= S_DONE;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign stall_o     = start_c || (state_q == S_REQ) || (state_q == S_WAIT);
   assign misalign_o  = (state_q == S_IDLE) && is_ls_i && misal_c;
   assign bus_err_o   = bus_err_q;
   assign rdata_o     = rdata_q;
   assign mem_valid_o = mem_valid_q;
   assign mem_we_o    = rw_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_wstrb_o = mem_wstrb_q;

endmodule
